// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter serialising two requesters onto a 4x16 register bank
module reg_bank_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [63:0] dbg_q
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;
  logic pri, cur_id, cur_wr, win, start, win_wr;
  logic [1:0] cur_addr, win_addr;
  logic [15:0] cur_wdata, win_wdata;
  logic [15:0] bank [4];
  logic [3:0] we;
  always_comb begin
    start = req0 | req1;
    win = (req0 & req1) ? pri : req1;
    win_wr = win ? wr1 : wr0;
    win_addr = win ? addr1 : addr0;
    win_wdata = win ? wdata1 : wdata0;
    state_nxt = (state == ACCESS) ? IDLE : (start ? ACCESS : IDLE);
    we = (state == ACCESS && cur_wr) ? 4'b0001 << cur_addr : 4'b0000;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // Command is captured on the IDLE->ACCESS edge; inputs are ignored during ACCESS
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pri <= 1'b0;
      cur_id <= 1'b0;
      cur_wr <= 1'b0;
      cur_addr <= 2'd0;
      cur_wdata <= 16'd0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      rdata0 <= 16'd0;
      rdata1 <= 16'd0;
    end else if (state == IDLE && start) begin
      cur_id <= win;
      cur_wr <= win_wr;
      cur_addr <= win_addr;
      cur_wdata <= win_wdata;
      gnt0 <= ~win;
      gnt1 <= win;
      if (!win_wr && !win) rdata0 <= bank[win_addr];
      if (!win_wr && win) rdata1 <= bank[win_addr];
    end else if (state == ACCESS) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      pri <= ~cur_id;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < 4; i++) bank[i] <= 16'd0;
    else for (int i = 0; i < 4; i++) if (we[i]) bank[i] <= cur_wdata;
  assign done0 = gnt0;
  assign done1 = gnt1;
  assign dbg_q = {bank[3], bank[2], bank[1], bank[0]};
endmodule
